// File: rtl/client_round_robin_arbiter.sv
// client_round_robin_arbiter
//   Shares one downstream resource among N clients. A registered one-hot grant
//   is held while its owner keeps requesting, for at most QUANTUM consecutive
//   cycles. On release or expiry the grant moves, with no gap, to the next
//   requester in circular order.
// Ports:
//   clock       - single clock, all state on posedge
//   reset_n     - asynchronous active-low reset
//   req[N]      - level-sensitive client requests, bit i = client i
//   grant[N]    - registered one-hot grant, all zero when idle
//   grant_valid - registered, equals |grant
//   grant_idx   - registered binary index of the owner, 0 when idle
module client_round_robin_arbiter #(
  parameter int N       = 8,
  parameter int QUANTUM = 4,
  parameter int IDX_W   = $clog2(N)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  localparam int CNT_W = $clog2(QUANTUM + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     grant_d;
  logic             valid_d;
  logic [IDX_W-1:0] idx_d;

  // Index one past i, wrapping at N (N need not be a power of two).
  function automatic logic [IDX_W-1:0] inc_mod(input logic [IDX_W-1:0] i);
    if (int'(i) >= N - 1) inc_mod = '0;
    else                  inc_mod = i + 1'b1;
  endfunction

  // First requester at or after start, circularly. Scanning offsets from the
  // far end down lets the nearest hit overwrite later ones. Callers only use
  // the result when r is non-zero.
  function automatic logic [IDX_W-1:0] pick(input logic [N-1:0] r,
                                            input logic [IDX_W-1:0] start);
    int j;
    pick = start;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(start) + k;
      if (j >= N) j = j - N;
      if (r[j]) pick = IDX_W'(j);
    end
  endfunction

  logic             any_req;
  logic             own_req;
  logic [IDX_W-1:0] w_idle, w_next;

  assign any_req = |req;
  assign own_req = req[grant_idx];
  assign w_idle  = pick(req, ptr_q);
  // Release and expiry both search from owner+1; the owner comes back only
  // when it is the sole requester.
  assign w_next  = pick(req, inc_mod(grant_idx));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant;
    valid_d = grant_valid;
    idx_d   = grant_idx;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          idx_d   = w_idle;
          grant_d = ONE_HOT0 << w_idle;
          valid_d = 1'b1;
          cnt_d   = CNT_W'(1);
          ptr_d   = inc_mod(w_idle);
        end
      end
      default: begin
        if (!any_req) begin
          // ptr already holds owner+1 from when this tenure started.
          state_d = IDLE;
          grant_d = '0;
          valid_d = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (own_req && (cnt_q < CNT_W'(QUANTUM))) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          idx_d   = w_next;
          grant_d = ONE_HOT0 << w_next;
          valid_d = 1'b1;
          cnt_d   = CNT_W'(1);
          ptr_d   = inc_mod(w_next);
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      grant       <= grant_d;
      grant_valid <= valid_d;
      grant_idx   <= idx_d;
    end
  end

endmodule

// File: tb/tb_client_round_robin_arbiter.sv
module tb_client_round_robin_arbiter;

  localparam int N     = 8;
  localparam int Q     = 4;
  localparam int IDX_W = $clog2(N);

  logic             clock;
  logic             reset_n;
  logic [N-1:0]     req;
  logic [N-1:0]     grant;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;

  int vectors = 0;
  int errors  = 0;

  // Reference state: owner (-1 when idle), cycles in current tenure, pointer.
  int m_own = -1;
  int m_cnt = 0;
  int m_ptr = 0;

  client_round_robin_arbiter #(.N(N), .QUANTUM(Q)) dut (
    .clock(clock), .reset_n(reset_n), .req(req),
    .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++)
      if (r[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] r);
    int w;
    if (m_own < 0) begin
      if (r != 0) begin
        w = pick(r, m_ptr);
        m_own = w; m_cnt = 1; m_ptr = (w + 1) % N;
      end
    end else if (r == 0) begin
      m_own = -1; m_cnt = 0;
    end else if (r[m_own] && m_cnt < Q) begin
      m_cnt++;
    end else begin
      w = pick(r, (m_own + 1) % N);
      m_own = w; m_cnt = 1; m_ptr = (w + 1) % N;
    end
  endtask

  always @(negedge reset_n) begin
    m_own = -1; m_cnt = 0; m_ptr = 0;
  end

  // Single compare process against the model, one check per cycle.
  always @(posedge clock) begin
    logic [N-1:0] eg;
    if (reset_n) model_step(req);
    #1;
    eg = (m_own < 0) ? '0 : (N'(1) << m_own);
    chk("model_grant", int'(grant), int'(eg));
    chk("model_valid", int'(grant_valid), (m_own >= 0) ? 1 : 0);
    chk("model_idx", int'(grant_idx), (m_own < 0) ? 0 : m_own);
  end

  task automatic do_reset();
    @(negedge clock);
    #2 reset_n = 1'b0;
    req = '0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int exp5 [8];
    reset_n = 1'b0;
    req     = '0;

    // 1: async reset mid-tenure, then first grant from ptr=0
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    req = 8'h08;
    repeat (3) @(negedge clock);
    chk("s1_pre_idx", int'(grant_idx), 3);
    #2 reset_n = 1'b0;
    #1;
    chk("s1_async_grant", int'(grant), 0);
    chk("s1_async_idx", int'(grant_idx), 0);
    chk("s1_async_valid", int'(grant_valid), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("s1_post_grant", int'(grant), 8'h08);
    chk("s1_post_idx", int'(grant_idx), 3);

    // 2: full load, 4 cycles each, 0..7 then wrap
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 36; k++) begin
      @(negedge clock);
      chk("s2_idx", int'(grant_idx), (k / 4) % 8);
      chk("s2_valid", int'(grant_valid), 1);
    end

    // 3: sole requester re-granted with no gap
    do_reset();
    req = 8'h04;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      chk("s3_grant", int'(grant), 8'h04);
    end

    // 4: early release hands over on the same edge
    do_reset();
    req = 8'h05;
    @(negedge clock);
    chk("s4_first", int'(grant_idx), 0);
    req = 8'h04;
    @(negedge clock);
    chk("s4_grant", int'(grant), 8'h04);
    chk("s4_idx", int'(grant_idx), 2);

    // 5: expiry wraps past 6,7 to 0, then back to 5
    do_reset();
    req = 8'h20;
    @(negedge clock);
    chk("s5_first", int'(grant_idx), 5);
    req = 8'h21;
    exp5 = '{5, 5, 5, 0, 0, 0, 0, 5};
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk("s5_idx", int'(grant_idx), exp5[k]);
    end

    // 6: idle then resume from saved pointer
    do_reset();
    req = 8'h40;
    @(negedge clock);
    chk("s6_first", int'(grant_idx), 6);
    req = 8'h00;
    @(negedge clock);
    chk("s6_idle", int'(grant_valid), 0);
    req = 8'h81;
    @(negedge clock);
    chk("s6_idx", int'(grant_idx), 7);
    chk("s6_grant", int'(grant), 8'h80);

    // Random traffic, occasional async reset
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      case ($urandom_range(0, 7))
        0:       req = '0;
        1, 2:    req = N'($urandom & $urandom);
        3:       req = N'($urandom);
        4:       req = N'(1) << $urandom_range(0, N - 1);
        default: ;
      endcase
      if ($urandom_range(0, 499) == 0) begin
        #2 reset_n = 1'b0;
        #1 chk("rnd_async", int'(grant_valid), 0);
        @(negedge clock);
        reset_n = 1'b1;
      end
    end

    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/client_round_robin_arbiter.md
# client_round_robin_arbiter

Round-robin arbiter that shares one downstream resource among `N` clients, each driving one bit of the shared `req` bus. It issues a registered one-hot grant and holds it while the owner keeps requesting, for at most `QUANTUM` consecutive cycles. When the owner drops its request or its quantum expires, the grant passes without a gap to the next requester in circular order. It sits between the client request bus and the shared resource, which consumes `grant`/`grant_idx` directly.

## Interface
- `N`, default 8: number of clients; must be ≥ 2.
- `QUANTUM`, default 4: maximum consecutive grant cycles per tenure; must be ≥ 1.
- `IDX_W`, default `$clog2(N)`: width of `grant_idx` (derived; do not override).
- `clock`  input  1: single clock; all state updates on its posedge.
- `reset_n`  input  1: asynchronous, active-low reset.
- `req`  input  N: client request bits. Bit i is client i. Each bit is level-sensitive and sampled at posedge.
- `grant`  output  N: registered one-hot grant, or all zero when idle.
- `grant_valid`  output  1: registered; equals `|grant`.
- `grant_idx`  output  IDX_W: registered binary index of the granted client; 0 when `grant_valid` is 0.

## Operation
- Internal state:
  - FSM with states IDLE and GRANT.
  - Priority pointer `ptr` (IDX_W bits).
  - Tenure counter `cnt` (width `$clog2(QUANTUM+1)`).
- Reset (async assert; state held while `reset_n` is low):
  - `grant`=0, `grant_valid`=0, `grant_idx`=0.
  - `ptr`=0, `cnt`=0, state=IDLE.
- Selection function `pick(start)` returns the first i with `req[i]`=1, searching circularly `start`, `start+1`, …, `N-1`, 0, …, `start-1`. Index arithmetic is modulo N and handles non-power-of-2 N.
- IDLE:
  - `req`=0: remain in IDLE.
  - Otherwise: winner w = `pick(ptr)`. Grant w. Set `cnt`=1, `ptr`=(w+1) mod N, go to GRANT.
- GRANT, owner o:
  - `req[o]`=1 and `cnt`<QUANTUM: keep o, `cnt`++.
  - `req[o]`=0 and some other req bit is 1: w = `pick((o+1) mod N)`. Grant w, `cnt`=1, `ptr`=(w+1) mod N.
  - `req[o]`=1 and `cnt`==QUANTUM: w = `pick((o+1) mod N)`, which returns o only if o is the sole requester. Grant w, `cnt`=1, `ptr`=(w+1) mod N. A sole requester is therefore re-granted with no gap.
  - `req`=0: clear the grant, go to IDLE. `ptr` keeps its value (o+1 mod N).
- With QUANTUM=1, the grant rotates every cycle among active requesters.
- Exactly one `grant` bit is set at a time. `grant`, `grant_valid` and `grant_idx` always update on the same edge.

## Timing
- Latency:
  - Request seen at posedge k while IDLE → grant visible after posedge k (1 cycle).
  - No combinational path from `req` to any output.
- Release: owner `req` low at posedge k → grant moves or clears at posedge k. No dead cycle on handover.
- Maximum tenure: QUANTUM cycles when a competitor is waiting. The worst-case wait for any requester is (N-1)·QUANTUM cycles.
- Simultaneous release and expiry: treated as release. The result is the same because the search starts at o+1 in both cases.
- Reset asserted mid-tenure: outputs go to 0 immediately, without waiting for a clock edge. After deassertion, the first grant comes from `ptr`=0.
- Deassertion of `reset_n` is assumed synchronous to `clock` (the upstream synchronizer provides this).

## Test plan
All scenarios use N=8, QUANTUM=4.
1. Reset: hold `req`=8'h08 and assert `reset_n` low mid-tenure → `grant`=0, `grant_idx`=0 with no clock edge. Release reset → `grant`=8'h08, `grant_idx`=3 one posedge later.
2. Full load: `req`=8'hFF held → grant is 0,1,…,7, then wraps to 0. Each owner holds exactly 4 cycles and every handover is gapless.
3. Sole requester: `req`=8'h04 held for 12 cycles → `grant`=8'h04 continuously; `cnt` wraps 1→4→1 with no gap.
4. Early release: `req`=8'h05 with client 0 owning. Drop bit 0 at cycle 2 → `grant`=8'h04 on that edge and `grant_idx`=2.
5. Wrap fairness: client 5 owns, `req`=8'h21 held → at expiry grant goes to 0 (wraps past 6 and 7). After 4 cycles it returns to 5.
6. Idle and resume: owner 6, all `req` drop → `grant_valid`=0 next edge. Then `req`=8'h81 → grant 7 (pointer was 7), `grant_idx`=7.
